response_framer: RTL and testbench

Parametrised successor to the single-byte response stage. It accepts decoded responses (request code plus a multi-byte payload) from the sensor decode path into a small FIFO. It serialises each response into a byte frame for `UART_TX`: mapped header, payload bytes MSB first, and an optional XOR checksum. Byte delivery to the transmitter uses a valid/ready handshake, so back-pressure from the UART is never lost.

---
 rtl/response_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 69 ++++++
 rtl/response_framer.sv | 198 +++++++++++++++++++
 tb/tb_response_framer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/response_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : response_pkg
// Purpose : Shared types and helpers for the response framer: the serialiser
//           state encoding and the request-code to header mapping.
// Ports   : (package, no ports)
// Rev     : 1.0  initial release
// ============================================================================
package response_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  // Valid codes 1..max_code map to code + offset (wrapping mod 256);
  // code 0 and anything above max_code map to the error header.
  function automatic logic [7:0] map_header(
    input logic [7:0] code,
    input logic [7:0] offset,
    input logic [7:0] max_code,
    input logic [7:0] error_code
  );
    if ((code != 8'd0) && (code <= max_code)) begin
      return code + offset;
    end
    return error_code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Purpose : Single-clock FIFO with show-ahead read data.
// Ports   : clock, reset (sync, active-high)
//           push, wr_data       - write side; ignored when full
//           pop                 - read side; ignored when empty
//           rd_data             - head entry (valid when !empty)
//           full, empty, count  - occupancy status from the registered count
// Rev     : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] c_ptr_one  = 1;
  localparam logic [PTR_W:0]   c_cnt_one  = 1;
  localparam logic [PTR_W:0]   c_cnt_full = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == c_cnt_full);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rd_data   = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/response_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : response_framer
// Purpose : Queues decoded responses and serialises each one into a UART byte
//           frame: mapped header, payload MSB first, optional XOR checksum.
// Ports   : clock, reset (sync, active-high)
//           in_valid/in_ready, in_code, in_data - response input (FIFO push)
//           tx_valid/tx_ready, tx_byte          - byte stream to the UART
//           frame_done                          - last byte handshake
//           busy                                - FSM active or FIFO non-empty
// Rev     : 1.0  initial release
// ============================================================================
module response_framer #(
  parameter int         DATA_BYTES  = 2,
  parameter int         DEPTH       = 4,
  parameter bit         CHECKSUM_EN = 1'b1,
  parameter logic [7:0] CODE_OFFSET = 8'h11,
  parameter int         MAX_CODE    = 8,
  parameter logic [7:0] ERROR_CODE  = 8'hFF
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_code,
  input  logic [8*DATA_BYTES-1:0]   in_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [7:0]                tx_byte,
  output logic                      frame_done,
  output logic                      busy
);

  import response_pkg::*;

  localparam int FW    = 8 + 8*DATA_BYTES;
  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(DATA_BYTES-1);
  localparam logic [IDX_W-1:0] c_idx_one  = 1;
  localparam logic [7:0]       c_max_code = 8'(MAX_CODE);

  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [FW-1:0]           w_fifo_rd;
  logic [CNT_W-1:0]        w_fifo_count;
  logic [CNT_W-1:0]        w_cnt_n;

  state_t                  r_state, w_state_n;
  logic [7:0]              r_code;
  logic [8*DATA_BYTES-1:0] r_data;
  logic [IDX_W-1:0]        r_idx, w_idx_n, w_idx_dec;
  logic [7:0]              r_tx_byte, w_tx_byte_n;
  logic                    r_tx_valid, w_tx_valid_n;
  logic                    r_busy, w_busy_n;

  logic [7:0]              w_bytes [DATA_BYTES];
  logic [7:0]              w_header;
  logic [7:0]              w_head_header;
  logic [7:0]              w_checksum;
  logic                    w_hs;
  logic                    w_last;
  logic                    w_finish;

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (w_push),
    .wr_data ({in_code, in_data}),
    .pop     (w_pop),
    .rd_data (w_fifo_rd),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_fifo_count)
  );

  // Readiness comes from the registered count only, so a same-cycle pop
  // never opens a full FIFO.
  assign in_ready = !w_fifo_full;
  assign w_push   = in_valid && in_ready;

  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_bytes
    assign w_bytes[i] = r_data[8*i +: 8];
  end

  assign w_header      = map_header(r_code, CODE_OFFSET, c_max_code, ERROR_CODE);
  assign w_head_header = map_header(w_fifo_rd[FW-1 -: 8], CODE_OFFSET, c_max_code, ERROR_CODE);
  assign w_idx_dec     = r_idx - c_idx_one;
  assign w_hs          = r_tx_valid && tx_ready;
  assign w_last        = (r_state == ST_CHECK) ||
                         ((r_state == ST_DATA) && (r_idx == '0) && !CHECKSUM_EN);

  always_comb begin
    w_checksum = w_header;
    for (int i = 0; i < DATA_BYTES; i++) begin
      w_checksum = w_checksum ^ w_bytes[i];
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_tx_byte_n  = r_tx_byte;
    w_tx_valid_n = r_tx_valid;
    w_pop        = 1'b0;
    w_finish     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          w_state_n = ST_HEADER;
        end
      end
      ST_HEADER: begin
        // Coming from IDLE the frame register was only just loaded, so the
        // header is registered onto the output one cycle later. Back-to-back
        // frames arrive here with the header already presented.
        if (!r_tx_valid) begin
          w_tx_valid_n = 1'b1;
          w_tx_byte_n  = w_header;
        end else if (w_hs) begin
          w_state_n   = ST_DATA;
          w_idx_n     = c_last_idx;
          w_tx_byte_n = w_bytes[c_last_idx];
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          if (r_idx != '0) begin
            w_idx_n     = w_idx_dec;
            w_tx_byte_n = w_bytes[w_idx_dec];
          end else if (CHECKSUM_EN) begin
            w_state_n   = ST_CHECK;
            w_tx_byte_n = w_checksum;
          end else begin
            w_finish = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (w_hs) w_finish = 1'b1;
      end
      default: w_state_n = ST_IDLE;
    endcase

    // Chain straight into the next queued response so there is no bubble.
    if (w_finish) begin
      if (!w_fifo_empty) begin
        w_pop       = 1'b1;
        w_state_n   = ST_HEADER;
        w_tx_byte_n = w_head_header;
      end else begin
        w_state_n    = ST_IDLE;
        w_tx_valid_n = 1'b0;
      end
    end
  end

  assign w_cnt_n  = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_busy_n = (w_state_n != ST_IDLE) || (w_cnt_n != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_tx_byte  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_code     <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_n;
      r_idx      <= w_idx_n;
      r_tx_byte  <= w_tx_byte_n;
      r_tx_valid <= w_tx_valid_n;
      r_busy     <= w_busy_n;
      if (w_pop) begin
        r_code <= w_fifo_rd[FW-1 -: 8];
        r_data <= w_fifo_rd[8*DATA_BYTES-1:0];
      end
    end
  end

  assign tx_valid   = r_tx_valid;
  assign tx_byte    = r_tx_byte;
  assign busy       = r_busy;
  // Marks the cycle in which the final byte is accepted.
  assign frame_done = r_tx_valid && tx_ready && w_last;

endmodule
`default_nettype wire

// File: tb/tb_response_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_response_framer
// Purpose : Directed self-checking bench for response_framer. A default
//           instance (2 payload bytes, checksum) and a 1-byte, no-checksum
//           instance share the clock and reset.
// Rev     : 1.0  initial release
// ============================================================================
module tb_response_framer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_code = '0;
  logic [15:0] in_data = '0;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_byte;
  logic        frame_done;
  logic        busy;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_in_code = '0;
  logic [7:0]  b_in_data = '0;
  logic        b_tx_valid;
  logic        b_tx_ready = 1'b1;
  logic [7:0]  b_tx_byte;
  logic        b_frame_done;
  logic        b_busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0]  f_code [5];
  logic [15:0] f_data [5];
  logic [7:0]  f_hdr  [5];
  logic [7:0]  f_cks  [5];

  always #5 clock = ~clock;

  response_framer u_dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_data    (in_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_byte    (tx_byte),
    .frame_done (frame_done),
    .busy       (busy)
  );

  response_framer #(
    .DATA_BYTES  (1),
    .CHECKSUM_EN (1'b0)
  ) u_dut_b (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_code    (b_in_code),
    .in_data    (b_in_data),
    .tx_valid   (b_tx_valid),
    .tx_ready   (b_tx_ready),
    .tx_byte    (b_tx_byte),
    .frame_done (b_frame_done),
    .busy       (b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one push that lands on the next posedge.
  task automatic push(input logic [7:0] code, input logic [15:0] data);
    in_valid = 1'b1;
    in_code  = code;
    in_data  = data;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for a byte, checks it, then lets it be accepted.
  task automatic rx(input string tag, input logic [7:0] exp_byte,
                    input logic exp_done, input int exp_wait);
    int w;
    w = 0;
    tx_ready = 1'b1;
    while (!tx_valid && w < 20) begin
      @(negedge clock);
      w++;
    end
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
    if (tx_valid) begin
      chk({tag, "_byte"}, 32'(tx_byte), 32'(exp_byte));
      chk({tag, "_done"}, 32'(frame_done), 32'(exp_done));
      if (exp_wait >= 0) chk({tag, "_wait"}, 32'(w), 32'(exp_wait));
    end
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    f_code[0] = 8'h01; f_data[0] = 16'h00FF; f_hdr[0] = 8'h12; f_cks[0] = 8'hED;
    f_code[1] = 8'h02; f_data[1] = 16'h1001; f_hdr[1] = 8'h13; f_cks[1] = 8'h02;
    f_code[2] = 8'h03; f_data[2] = 16'h1A2B; f_hdr[2] = 8'h14; f_cks[2] = 8'h25;
    f_code[3] = 8'h04; f_data[3] = 16'h8000; f_hdr[3] = 8'h15; f_cks[3] = 8'h95;
    f_code[4] = 8'h05; f_data[4] = 16'h0F0F; f_hdr[4] = 8'h16; f_cks[4] = 8'h16;

    // ---- reset ----
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk("rst_tx_valid",   32'(tx_valid),   32'd0);
    chk("rst_tx_byte",    32'(tx_byte),    32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd1);

    // ---- basic frame, header two cycles after the push ----
    push(8'h03, 16'h1A2B);
    chk("t1_busy_after_push", 32'(busy), 32'd1);
    rx("t1_hdr", 8'h14, 1'b0, 2);
    rx("t1_d1",  8'h1A, 1'b0, 0);
    rx("t1_d0",  8'h2B, 1'b0, 0);
    rx("t1_cks", 8'h25, 1'b1, 0);
    chk("t1_idle_valid", 32'(tx_valid), 32'd0);
    chk("t1_idle_busy",  32'(busy),     32'd0);

    // ---- invalid codes 0 and 9 map to the error header ----
    in_valid = 1'b1; in_code = 8'h00; in_data = 16'h0000;
    @(negedge clock);
    in_code = 8'h09;
    @(negedge clock);
    in_valid = 1'b0;
    rx("t2_hdr0", 8'hFF, 1'b0, -1);
    rx("t2_a1",   8'h00, 1'b0, 0);
    rx("t2_a0",   8'h00, 1'b0, 0);
    rx("t2_cks0", 8'hFF, 1'b1, 0);
    rx("t2_hdr9", 8'hFF, 1'b0, 0);
    rx("t2_b1",   8'h00, 1'b0, 0);
    rx("t2_b0",   8'h00, 1'b0, 0);
    rx("t2_cks9", 8'hFF, 1'b1, 0);

    // ---- back-pressure on a payload byte ----
    push(8'h03, 16'h1A2B);
    rx("t3_hdr", 8'h14, 1'b0, 2);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", 32'(tx_valid), 32'd1);
      chk("t3_hold_byte",  32'(tx_byte),  32'h1A);
      @(negedge clock);
    end
    rx("t3_d1",  8'h1A, 1'b0, 0);
    rx("t3_d0",  8'h2B, 1'b0, 0);
    rx("t3_cks", 8'h25, 1'b1, 0);

    // ---- fill: FIFO plus frame register, then drain in order ----
    tx_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) begin
        if (acc < 5) begin
          in_code = f_code[acc];
          in_data = f_data[acc];
        end
        acc++;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("t4_accepted", 32'(acc),      32'd5);
    chk("t4_full",     32'(in_ready), 32'd0);
    chk("t4_hdr_held", 32'(tx_byte),  32'h12);
    for (int f = 0; f < 5; f++) begin
      rx("t4_hdr", f_hdr[f], 1'b0, 0);
      if (f == 0) chk("t4_still_full", 32'(in_ready), 32'd0);
      rx("t4_d1",  f_data[f][15:8], 1'b0, 0);
      rx("t4_d0",  f_data[f][7:0],  1'b0, 0);
      rx("t4_cks", f_cks[f], 1'b1, 0);
      if (f == 0) chk("t4_ready_after_pop", 32'(in_ready), 32'd1);
    end
    chk("t4_drained", 32'(tx_valid), 32'd0);

    // ---- 1-byte payload, no checksum, highest valid code ----
    b_in_valid = 1'b1; b_in_code = 8'h08; b_in_data = 8'h7E;
    @(negedge clock);
    b_in_valid = 1'b0;
    @(negedge clock);
    chk("t5_lat_valid", 32'(b_tx_valid), 32'd0);
    @(negedge clock);
    chk("t5_hdr_valid", 32'(b_tx_valid),   32'd1);
    chk("t5_hdr_byte",  32'(b_tx_byte),    32'h19);
    chk("t5_hdr_done",  32'(b_frame_done), 32'd0);
    @(negedge clock);
    chk("t5_d_byte",    32'(b_tx_byte),    32'h7E);
    chk("t5_d_done",    32'(b_frame_done), 32'd1);
    @(negedge clock);
    chk("t5_end_valid", 32'(b_tx_valid),   32'd0);

    // ---- reset mid-payload with two frames queued ----
    in_valid = 1'b1; in_code = f_code[0]; in_data = f_data[0];
    @(negedge clock);
    in_code = f_code[1]; in_data = f_data[1];
    @(negedge clock);
    in_code = f_code[2]; in_data = f_data[2];
    @(negedge clock);
    in_valid = 1'b0;
    rx("t6_hdr", 8'h12, 1'b0, -1);
    rx("t6_d1",  8'h00, 1'b0, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_rst_tx_valid",   32'(tx_valid),   32'd0);
    chk("t6_rst_tx_byte",    32'(tx_byte),    32'd0);
    chk("t6_rst_frame_done", 32'(frame_done), 32'd0);
    chk("t6_rst_busy",       32'(busy),       32'd0);
    chk("t6_rst_in_ready",   32'(in_ready),   32'd1);
    reset = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("t6_quiet_valid", 32'(tx_valid), 32'd0);
    end
    chk("t6_quiet_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
`default_nettype wire
